completion_arbiter: RTL

Shares the reorder buffer's three completion ports among NUM_FU functional units. Each FU hands a finished result (ROB index, destination tag, 32-bit data) to the arbiter over a valid/ready handshake. The arbiter holds it in a one-entry per-FU buffer and grants up to NUM_PORTS buffered results per cycle in rotating-priority order. Granted results drive the ROB `rob_index` / `tag_rd_complete` / `data_rd` / `complete` inputs from registers.

---
 rtl/completion_arbiter_if.sv | 41 ++++
 rtl/completion_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/completion_arbiter_if.sv
// Completion bus between the functional units, the arbiter and the ROB
// completion ports. The FU side offers results with fu_valid and the
// arbiter accepts them with fu_ready. The ROB side is a registered,
// valid-only interface qualified by complete[k].
interface completion_arbiter_if #(
   parameter int NUM_FU        = 5,
   parameter int NUM_PORTS     = 3,
   parameter int ROB_SIZE      = 64,
   parameter int NUM_TAGS_LOG2 = 6,
   parameter int REG_SIZE      = 32
);
   localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE);

   // Handshake: a result moves from FU i into the arbiter on a rising edge
   // where fu_valid[i] and fu_ready[i] are both 1. While fu_valid[i] is 1
   // and fu_ready[i] is 0, the FU holds its fu_* fields stable. fu_ready
   // never depends on fu_valid of the same FU.
   logic                     flush;
   logic [NUM_FU-1:0]        fu_valid;
   logic [ROB_SIZE_LOG2-1:0] fu_rob_index [NUM_FU];
   logic [NUM_TAGS_LOG2-1:0] fu_tag       [NUM_FU];
   logic [REG_SIZE-1:0]      fu_data      [NUM_FU];
   logic [NUM_FU-1:0]        fu_ready;

   // ROB completion ports. Bit k of complete qualifies port k.
   logic [ROB_SIZE_LOG2-1:0] rob_index       [NUM_PORTS];
   logic [NUM_TAGS_LOG2-1:0] tag_rd_complete [NUM_PORTS];
   logic [REG_SIZE-1:0]      data_rd         [NUM_PORTS];
   logic [NUM_PORTS-1:0]     complete;
   logic                     busy;

   modport master (
      output flush, fu_valid, fu_rob_index, fu_tag, fu_data,
      input  fu_ready, rob_index, tag_rd_complete, data_rd, complete, busy
   );

   modport slave (
      input  flush, fu_valid, fu_rob_index, fu_tag, fu_data,
      output fu_ready, rob_index, tag_rd_complete, data_rd, complete, busy
   );
endinterface

// File: rtl/completion_arbiter.sv
// Completion arbiter: one result buffer per functional unit. Up to
// NUM_PORTS buffered results are granted per cycle in rotating-priority
// order and are registered onto the ROB completion ports. The rotating
// pointer is exported on dbg_rr_o.
module completion_arbiter #(
   parameter int NUM_FU        = 5,
   parameter int NUM_PORTS     = 3,
   parameter int ROB_SIZE      = 64,
   parameter int NUM_TAGS_LOG2 = 6,
   parameter int REG_SIZE      = 32,
   localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE),
   localparam int FU_W          = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                clk,
   input  logic                rst,
   completion_arbiter_if.slave bus,
   output logic [FU_W-1:0]     dbg_rr_o
);

   // Per-FU result buffers
   logic [NUM_FU-1:0]        pend_q;
   logic [ROB_SIZE_LOG2-1:0] buf_idx_q  [NUM_FU];
   logic [NUM_TAGS_LOG2-1:0] buf_tag_q  [NUM_FU];
   logic [REG_SIZE-1:0]      buf_data_q [NUM_FU];

   // Rotating priority pointer: the first FU index examined each cycle
   logic [FU_W-1:0] rr_q;
   logic [FU_W-1:0] rr_d;

   // Registered ROB completion ports
   logic [ROB_SIZE_LOG2-1:0] out_idx_q  [NUM_PORTS];
   logic [NUM_TAGS_LOG2-1:0] out_tag_q  [NUM_PORTS];
   logic [REG_SIZE-1:0]      out_data_q [NUM_PORTS];
   logic [NUM_PORTS-1:0]     out_vld_q;

   // Selection results
   logic [NUM_FU-1:0]    grant;
   logic [FU_W-1:0]      port_sel [NUM_PORTS];
   logic [NUM_PORTS-1:0] port_vld;
   logic [FU_W-1:0]      last_idx;
   logic [FU_W:0]        scan_sum;
   logic [FU_W-1:0]      scan_idx;
   int                   grant_cnt;

   logic [NUM_FU-1:0] accept;

   // Rotating-priority scan: the k-th pending FU found from rr gets port k
   always_comb begin
      grant     = '0;
      port_vld  = '0;
      last_idx  = rr_q;
      grant_cnt = 0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         port_sel[k] = '0;
      end
      for (int off = 0; off < NUM_FU; off++) begin
         // rr_q and off are both below NUM_FU, so one subtraction wraps the sum
         scan_sum = {1'b0, rr_q} + (FU_W+1)'(off);
         if (scan_sum >= (FU_W+1)'(NUM_FU)) begin
            scan_sum = scan_sum - (FU_W+1)'(NUM_FU);
         end
         scan_idx = scan_sum[FU_W-1:0];
         if (pend_q[scan_idx] && (grant_cnt < NUM_PORTS)) begin
            grant[scan_idx] = 1'b1;
            for (int k = 0; k < NUM_PORTS; k++) begin
               if (grant_cnt == k) begin
                  port_sel[k] = scan_idx;
                  port_vld[k] = 1'b1;
               end
            end
            grant_cnt = grant_cnt + 1;
            last_idx  = scan_idx;
         end
      end
   end

   // Next pointer: one past the last granted FU, held when nothing is granted
   always_comb begin
      rr_d = rr_q;
      if (|grant) begin
         rr_d = (last_idx == FU_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
      end
   end

   // A buffer accepts when it is empty or is being drained this cycle
   assign bus.fu_ready = {NUM_FU{~rst & ~bus.flush}} & (~pend_q | grant);
   assign accept       = bus.fu_valid & bus.fu_ready;

   // Buffer capture, grant retirement, output registers and pointer update
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= '0;
         rr_q      <= '0;
         out_vld_q <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            buf_idx_q[i]  <= '0;
            buf_tag_q[i]  <= '0;
            buf_data_q[i] <= '0;
         end
         for (int k = 0; k < NUM_PORTS; k++) begin
            out_idx_q[k]  <= '0;
            out_tag_q[k]  <= '0;
            out_data_q[k] <= '0;
         end
      end else if (bus.flush) begin
         // Drop everything in flight; the pointer keeps its position
         pend_q    <= '0;
         out_vld_q <= '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            out_idx_q[k]  <= '0;
            out_tag_q[k]  <= '0;
            out_data_q[k] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
               pend_q[i]     <= 1'b1;
               buf_idx_q[i]  <= bus.fu_rob_index[i];
               buf_tag_q[i]  <= bus.fu_tag[i];
               buf_data_q[i] <= bus.fu_data[i];
            end else if (grant[i]) begin
               pend_q[i] <= 1'b0;
            end
         end
         out_vld_q <= port_vld;
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_vld[k]) begin
               out_idx_q[k]  <= buf_idx_q[port_sel[k]];
               out_tag_q[k]  <= buf_tag_q[port_sel[k]];
               out_data_q[k] <= buf_data_q[port_sel[k]];
            end else begin
               out_idx_q[k]  <= '0;
               out_tag_q[k]  <= '0;
               out_data_q[k] <= '0;
            end
         end
         rr_q <= rr_d;
      end
   end

   assign bus.complete = out_vld_q;
   assign bus.busy     = |pend_q;
   assign dbg_rr_o     = rr_q;

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      assign bus.rob_index[k]       = out_idx_q[k];
      assign bus.tag_rd_complete[k] = out_tag_q[k];
      assign bus.data_rd[k]         = out_data_q[k];
   end

endmodule
